// File: rtl/fs_accel_mpool_drain_pkg.sv
// Shared types and widths for the max-pool drain path.
// Holds the FSM encoding and the signed max helper.
package fs_accel_mpool_drain_pkg;

    localparam int FS_DATA_W = 8;
    localparam int FS_CNT_W  = 16;

    typedef enum logic [1:0] {
        MPD_IDLE  = 2'd0,
        MPD_ACCUM = 2'd1,
        MPD_DRAIN = 2'd2
    } mpd_state_t;

    typedef logic signed [FS_DATA_W-1:0] act_t;

    // Ties keep b, so the running max holds on equal values
    function automatic act_t smax(act_t a, act_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fs_accel_mpool_drain_if.sv
// Activation-in / pooled-out stream bundle.
// slave is the pooling block, master is the producer/consumer.
interface fs_accel_mpool_drain_if;
    import fs_accel_mpool_drain_pkg::*;

    act_t in_data;
    logic in_valid;
    logic in_ready;
    act_t out_data;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/fs_accel_mpool_ofifo.sv
// Small synchronous output FIFO for pooled results.
// Push and pop may coincide, even when full.
module fs_accel_mpool_ofifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fs_accel_mpool_drain.sv
// Max-pool drain: running signed max per window,
// one pooled int8 per window through a small FIFO.
module fs_accel_mpool_drain
    import fs_accel_mpool_drain_pkg::*;
#(
    parameter int WIN_LEN   = 4,
    parameter int OFIFO_DEP = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enb,
    input  logic                start,
    input  logic [FS_CNT_W-1:0] cfg_num_win,
    fs_accel_mpool_drain_if.slave strm,
    output logic                busy,
    output logic                done
);

    localparam logic [7:0] LAST = 8'(WIN_LEN - 1);

    mpd_state_t          state;
    mpd_state_t          state_nx;
    logic [7:0]          elem_cnt;
    logic [FS_CNT_W-1:0] win_cnt;
    logic [FS_CNT_W-1:0] num_win;
    act_t                max_r;
    act_t                push_val;
    act_t                head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                in_fire;
    logic                push;
    logic                pop;
    logic                last_win;

    assign in_fire  = strm.in_valid & strm.in_ready;
    assign push     = in_fire & (elem_cnt == LAST);
    assign pop      = strm.out_valid & strm.out_ready;
    assign last_win = ({1'b0, win_cnt} + 17'd1)
                   == {1'b0, num_win};
    // First beat of a window seeds the max
    assign push_val = (elem_cnt == 8'd0) ? strm.in_data
                    : smax(strm.in_data, max_r);

    assign strm.out_valid = enb & ~fifo_empty;
    assign strm.out_data  = fifo_empty ? '0 : head;
    assign busy           = (state != MPD_IDLE);

    always_comb begin
        state_nx      = state;
        strm.in_ready = 1'b0;
        done          = 1'b0;
        unique case (state)
            MPD_IDLE: begin
                if (start && enb)
                    state_nx = (cfg_num_win == '0)
                             ? MPD_DRAIN : MPD_ACCUM;
            end
            MPD_ACCUM: begin
                strm.in_ready = enb & ~fifo_full;
                if (push && last_win)
                    state_nx = MPD_DRAIN;
            end
            MPD_DRAIN: begin
                if (enb && fifo_empty) begin
                    done     = 1'b1;
                    state_nx = MPD_IDLE;
                end
            end
            default: state_nx = MPD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= MPD_IDLE;
        else if (enb)
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            elem_cnt <= '0;
            win_cnt  <= '0;
            num_win  <= '0;
            max_r    <= '0;
        end else if (enb) begin
            if (state == MPD_IDLE && start) begin
                num_win  <= cfg_num_win;
                win_cnt  <= '0;
                elem_cnt <= '0;
            end
            if (in_fire) begin
                max_r <= push_val;
                if (elem_cnt == LAST) begin
                    elem_cnt <= '0;
                    win_cnt  <= win_cnt + 16'd1;
                end else begin
                    elem_cnt <= elem_cnt + 8'd1;
                end
            end
        end
    end

    fs_accel_mpool_ofifo #(
        .DATA_W (FS_DATA_W),
        .DEPTH  (OFIFO_DEP)
    ) u_ofifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .pop       (pop),
        .push_data (push_val),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

endmodule
